sh7604_ubc_match: RTL and testbench
===================================

Name: sh7604_ubc_match

Overview:
Break-condition engine that consumes the UBC register file contents and produces the break request the register block currently ties off.
- Snoops every internal-bus cycle (CPU or DMAC) and compares it against channels A and B: address, bus-cycle qualifiers, and data (channel B only).
- Applies sequential and PC-break timing, then raises a level interrupt to the interrupt controller.
- Emits condition-match flag pulses back to the register block for BRCR.

Parameters:
- none

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- CE_R  in  1  rising-phase clock enable; all state updates only when CE_R=1
- BARA  in  32  channel A address ({BARAH,BARAL})
- BAMRA  in  32  channel A address mask; 1 = don't care
- BBRA  in  16  channel A bus-cycle qualifier
- BARB  in  32  channel B address
- BAMRB  in  32  channel B address mask
- BBRB  in  16  channel B bus-cycle qualifier
- BDRB  in  32  channel B data
- BDMRB  in  32  channel B data mask; 1 = don't care
- BRCR  in  16  break control register
- BUS_VALID  in  1  snooped bus cycle valid this CE_R
- BUS_A  in  32  snooped address
- BUS_D  in  32  snooped data, big-endian lanes
- BUS_WE  in  1  1 = write
- BUS_SZ  in  2  01 byte, 10 word, 11 long
- BUS_IF  in  1  1 = instruction fetch, 0 = data
- BUS_DMA  in  1  1 = DMAC (peripheral) cycle, 0 = CPU
- INSN_END  in  1  pulse: the CPU has retired an instruction
- IRQ_ACK  in  1  pulse: break exception accepted
- CMFA_SET  out  1  one-cycle pulse: set BRCR CMFCA (CPU) / CMFPA (DMAC)
- CMFB_SET  out  1  one-cycle pulse: set CMFCB / CMFPB
- CMF_DMA  out  1  qualifies CMFx_SET: 1 = DMAC-side flag
- IRQ  out  1  break request level

Behaviour:
BBRx field layout:
- [7:6] CP: 01 CPU, 10 DMAC, 11 both.
- [5:4] ID: 01 fetch, 10 data, 11 both.
- [3:2] RW: 01 read, 10 write, 11 both.
- [1:0] SZ: 00 any, otherwise it must equal BUS_SZ.
- If any of CP, ID or RW is 00, the channel never matches.

Address match: ((BUS_A ^ BARx) & ~BAMRx) == 0.

Channel B data match:
- Applies only when BRCR.DBEB[2]=1 and BUS_IF=0. Otherwise the data term is ignored (treated as match).
- Byte: BUS_D lane (A[1:0]=0 selects [31:24], up to 3 selects [7:0]) is compared with BDRB[7:0] under BDMRB[7:0].
- Word: lane [31:16] when A[1]=0, [15:0] when A[1]=1; compared with BDRB[15:0] under BDMRB[15:0].
- Long: full 32-bit compare under the full mask.

Stage 1: comb_match_{A,B} = BUS_VALID & CE_R & address & qualifier & data terms.

Stage 2, registered on CE_R:
- CMFA_SET / CMFB_SET are asserted one CE_R after the bus cycle.
- CMF_DMA is the registered BUS_DMA.

Sequence, BRCR.SEQ[3]:
- SEQ=0: brk = mA | mB.
- SEQ=1: an A match sets ARMED. A B match while ARMED produces brk and clears ARMED; a B match without ARMED produces no brk (its flag still pulses).
- If A and B match on the same cycle with ARMED=0, ARMED is set and there is no brk.
- If A and B match on the same cycle with ARMED=1, brk fires and ARMED stays set.
- ARMED is cleared when SEQ=0.

PC-break timing:
- Applies when the matching channel's cycle was a fetch and its PCB bit is 1 (BRCR.PCBA[10] / PCBB[1]).
- brk is deferred: DEFER is set, and IRQ is raised on the first INSN_END seen on a later CE_R.
- In every other case, IRQ is set in the same cycle as CMFx_SET.

IRQ handling:
- IRQ stays high until IRQ_ACK.
- IRQ_ACK and a new brk on the same CE_R: IRQ stays 1 (set wins).
- Matches while IRQ is high still pulse their flags, but no additional queueing.

Reset: RST=1 on a CLK edge, regardless of CE_R, clears IRQ, CMFA_SET, CMFB_SET, CMF_DMA, ARMED and DEFER. Any pending or deferred break is discarded.

Output hold: outputs hold their value when CE_R=0.

Decomposition:
- SH7604_PKG gains:
  - BBR field typedef (cp, id, rw, sz).
  - BRCR bit-position constants: PCBA, DBEB, SEQ, PCBB.
  - Size encodings SZ_BYTE / SZ_WORD / SZ_LONG.
- Sub-module sh7604_ubc_chan_cmp:
  - Combinational address, qualifier and optional data compare.
  - Instantiated for A (data compare disabled) and B.

Test Plan:
- BARA=0x06001000, BAMRA=0, BBRA=CPU/data/write/long; CPU long write to 0x06001000 -> CMFA_SET pulse one CE_R later, CMF_DMA=0, IRQ=1 until IRQ_ACK; write to 0x06001004 -> nothing.
- BAMRB=0xF, BBRB=both/data/read/any, DBEB=1, BDRB=0x000000AB, BDMRB=0; byte read at 0x06002003 with D[7:0]=0xAB -> CMFB_SET+IRQ; same with D=0xAC -> none.
- SEQ=1: B match alone -> CMFB_SET but IRQ=0; then A match -> ARMED, no IRQ; then B match -> IRQ=1 and ARMED cleared.
- PCBA=1, fetch match on A -> CMFA_SET but IRQ=0; INSN_END two CE_R later -> IRQ=1 on that edge.
- IRQ high; IRQ_ACK on the same CE_R as a new A match -> IRQ remains 1; next IRQ_ACK alone -> IRQ=0.
- RST asserted while DEFER and ARMED are set -> all outputs 0; subsequent INSN_END and B match raise no IRQ.

Source files
------------

// File: rtl/sh7604_ubc_match_pkg.sv
// Shared types and constants for the SH7604 user break controller match engine.
package sh7604_ubc_match_pkg;

    // Low byte of BBRA/BBRB: bus-cycle qualifier fields.
    typedef struct packed {
        logic [1:0] cp;   // 01 CPU, 10 DMAC, 11 both
        logic [1:0] id;   // 01 fetch, 10 data, 11 both
        logic [1:0] rw;   // 01 read, 10 write, 11 both
        logic [1:0] sz;   // 00 any, else exact bus size
    } bbr_t;

    // BRCR bit positions used by the match engine.
    localparam int unsigned BRCR_PCBB = 1;
    localparam int unsigned BRCR_DBEB = 2;
    localparam int unsigned BRCR_SEQ  = 3;
    localparam int unsigned BRCR_PCBA = 10;

    // Bus access size encodings.
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_LONG = 2'b11;

    // Two-bit "which kinds are enabled" field: bit 0 selects the first kind,
    // bit 1 the second. A 00 field therefore never matches.
    function automatic logic field_hit(input logic [1:0] f, input logic second);
        return second ? f[1] : f[0];
    endfunction

    // Sequential-break tracking.
    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_ARMED = 1'b1
    } seq_state_t;

endpackage

// File: rtl/sh7604_ubc_chan_cmp.sv
// One UBC channel comparator: address, bus-cycle qualifier and optional data.
module sh7604_ubc_chan_cmp
    import sh7604_ubc_match_pkg::*;
(
    input  logic [31:0] i_bar,
    input  logic [31:0] i_bamr,
    input  logic [7:0]  i_bbr,
    input  logic [31:0] i_bdr,
    input  logic [31:0] i_bdmr,
    input  logic        i_data_en,
    input  logic [31:0] i_bus_a,
    input  logic [31:0] i_bus_d,
    input  logic        i_bus_we,
    input  logic [1:0]  i_bus_sz,
    input  logic        i_bus_if,
    input  logic        i_bus_dma,
    output logic        o_match
);

    bbr_t        w_bbr;
    logic        w_addr_ok;
    logic        w_qual_ok;
    logic        w_data_ok;
    logic [31:0] w_lane_d;
    logic [31:0] w_lane_r;
    logic [31:0] w_lane_m;

    assign w_bbr     = bbr_t'(i_bbr);
    assign w_addr_ok = ((i_bus_a ^ i_bar) & ~i_bamr) == '0;

    // Qualifier: cycle source, fetch/data, read/write and size must all be enabled.
    always_comb begin
        w_qual_ok = field_hit(w_bbr.cp, i_bus_dma)
                  & field_hit(w_bbr.id, ~i_bus_if)
                  & field_hit(w_bbr.rw, i_bus_we)
                  & ((w_bbr.sz == 2'b00) | (w_bbr.sz == i_bus_sz));
    end

    // Data lane extraction; unused upper bits are forced don't-care via the mask.
    always_comb begin
        w_lane_d = i_bus_d;
        w_lane_r = i_bdr;
        w_lane_m = i_bdmr;
        case (i_bus_sz)
            SZ_BYTE: begin
                // A[1:0]=0 is the most significant lane (big-endian)
                w_lane_d = i_bus_d >> {~i_bus_a[1:0], 3'b000};
                w_lane_r = {24'h0, i_bdr[7:0]};
                w_lane_m = {24'hFF_FFFF, i_bdmr[7:0]};
            end
            SZ_WORD: begin
                w_lane_d = i_bus_a[1] ? {16'h0, i_bus_d[15:0]} : {16'h0, i_bus_d[31:16]};
                w_lane_r = {16'h0, i_bdr[15:0]};
                w_lane_m = {16'hFFFF, i_bdmr[15:0]};
            end
            default: begin
                w_lane_d = i_bus_d;
                w_lane_r = i_bdr;
                w_lane_m = i_bdmr;
            end
        endcase
    end

    assign w_data_ok = ((w_lane_d ^ w_lane_r) & ~w_lane_m) == '0;

    // Data term only applies to data cycles with data compare enabled.
    assign o_match = w_addr_ok & w_qual_ok & (~i_data_en | i_bus_if | w_data_ok);

endmodule

// File: rtl/sh7604_ubc_match.sv
// UBC break-condition engine: channel matching, sequencing, PC-break deferral, IRQ.
module sh7604_ubc_match
    import sh7604_ubc_match_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic [31:0] BARA,
    input  logic [31:0] BAMRA,
    input  logic [15:0] BBRA,
    input  logic [31:0] BARB,
    input  logic [31:0] BAMRB,
    input  logic [15:0] BBRB,
    input  logic [31:0] BDRB,
    input  logic [31:0] BDMRB,
    input  logic [15:0] BRCR,
    input  logic        BUS_VALID,
    input  logic [31:0] BUS_A,
    input  logic [31:0] BUS_D,
    input  logic        BUS_WE,
    input  logic [1:0]  BUS_SZ,
    input  logic        BUS_IF,
    input  logic        BUS_DMA,
    input  logic        INSN_END,
    input  logic        IRQ_ACK,
    output logic        CMFA_SET,
    output logic        CMFB_SET,
    output logic        CMF_DMA,
    output logic        IRQ
);

    logic       w_cmp_a;
    logic       w_cmp_b;
    logic       w_match_a;
    logic       w_match_b;
    logic       w_seq_en;
    logic       w_brk_a;
    logic       w_brk_b;
    logic       w_pcb_a;
    logic       w_pcb_b;
    logic       w_brk_now;
    logic       w_defer_set;
    logic       w_defer_fire;
    logic       w_irq_busy;
    logic       w_defer_nxt;
    logic       w_irq_nxt;
    logic       w_unused;

    seq_state_t r_seq_state;
    seq_state_t w_seq_nxt;

    logic       r_cmfa;
    logic       r_cmfb;
    logic       r_cmf_dma;
    logic       r_defer;
    logic       r_irq;

    assign w_unused = ^{BBRA[15:8], BBRB[15:8], BRCR[15:11], BRCR[9:4], BRCR[0]};

    sh7604_ubc_chan_cmp u_cmp_a (
        .i_bar     (BARA),
        .i_bamr    (BAMRA),
        .i_bbr     (BBRA[7:0]),
        .i_bdr     ('0),
        .i_bdmr    ('1),
        .i_data_en (1'b0),
        .i_bus_a   (BUS_A),
        .i_bus_d   (BUS_D),
        .i_bus_we  (BUS_WE),
        .i_bus_sz  (BUS_SZ),
        .i_bus_if  (BUS_IF),
        .i_bus_dma (BUS_DMA),
        .o_match   (w_cmp_a)
    );

    sh7604_ubc_chan_cmp u_cmp_b (
        .i_bar     (BARB),
        .i_bamr    (BAMRB),
        .i_bbr     (BBRB[7:0]),
        .i_bdr     (BDRB),
        .i_bdmr    (BDMRB),
        .i_data_en (BRCR[BRCR_DBEB]),
        .i_bus_a   (BUS_A),
        .i_bus_d   (BUS_D),
        .i_bus_we  (BUS_WE),
        .i_bus_sz  (BUS_SZ),
        .i_bus_if  (BUS_IF),
        .i_bus_dma (BUS_DMA),
        .o_match   (w_cmp_b)
    );

    assign w_match_a = BUS_VALID & CE_R & w_cmp_a;
    assign w_match_b = BUS_VALID & CE_R & w_cmp_b;
    assign w_seq_en  = BRCR[BRCR_SEQ];

    // Sequence FSM: state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_seq_state <= SEQ_IDLE;
        end else if (CE_R) begin
            r_seq_state <= w_seq_nxt;
        end
    end

    // Sequence FSM: next state. An A match always arms (also when B hits on the
    // same cycle); a lone B match consumes the armed state.
    always_comb begin
        w_seq_nxt = r_seq_state;
        if (!w_seq_en) begin
            w_seq_nxt = SEQ_IDLE;
        end else if (w_match_a) begin
            w_seq_nxt = SEQ_ARMED;
        end else if (w_match_b && r_seq_state == SEQ_ARMED) begin
            w_seq_nxt = SEQ_IDLE;
        end
    end

    // Sequence FSM: break source per channel.
    always_comb begin
        w_brk_a = 1'b0;
        w_brk_b = 1'b0;
        if (!w_seq_en) begin
            w_brk_a = w_match_a;
            w_brk_b = w_match_b;
        end else begin
            w_brk_b = w_match_b & (r_seq_state == SEQ_ARMED);
        end
    end

    // PC-break split: fetch breaks on a PCB channel wait for instruction retire.
    always_comb begin
        w_pcb_a      = BUS_IF & BRCR[BRCR_PCBA];
        w_pcb_b      = BUS_IF & BRCR[BRCR_PCBB];
        w_brk_now    = (w_brk_a & ~w_pcb_a) | (w_brk_b & ~w_pcb_b);
        w_defer_set  = (w_brk_a & w_pcb_a) | (w_brk_b & w_pcb_b);
        w_defer_fire = r_defer & INSN_END;
        w_irq_busy   = r_irq & ~IRQ_ACK;
        // New deferrals are not queued behind an outstanding request.
        w_defer_nxt  = (w_defer_set & ~w_irq_busy) | (r_defer & ~INSN_END);
        w_irq_nxt    = w_brk_now | w_defer_fire | w_irq_busy;
    end

    // Flag pulses, DEFER and IRQ; everything holds while CE_R is low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cmfa    <= 1'b0;
            r_cmfb    <= 1'b0;
            r_cmf_dma <= 1'b0;
            r_defer   <= 1'b0;
            r_irq     <= 1'b0;
        end else if (CE_R) begin
            r_cmfa    <= w_match_a;
            r_cmfb    <= w_match_b;
            r_cmf_dma <= BUS_DMA;
            r_defer   <= w_defer_nxt;
            r_irq     <= w_irq_nxt;
        end
    end

    assign CMFA_SET = r_cmfa;
    assign CMFB_SET = r_cmfb;
    assign CMF_DMA  = r_cmf_dma;
    assign IRQ      = r_irq;

endmodule

// File: tb/tb_sh7604_ubc_match.sv
// Self-checking bench for sh7604_ubc_match: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_sh7604_ubc_match;

    logic        CLK = 1'b0;
    logic        RST, CE_R;
    logic [31:0] BARA, BAMRA, BARB, BAMRB, BDRB, BDMRB;
    logic [15:0] BBRA, BBRB, BRCR;
    logic        BUS_VALID, BUS_WE, BUS_IF, BUS_DMA, INSN_END, IRQ_ACK;
    logic [31:0] BUS_A, BUS_D;
    logic [1:0]  BUS_SZ;
    logic        CMFA_SET, CMFB_SET, CMF_DMA, IRQ;

    int total = 0;
    int bad   = 0;

    // model state
    bit m_cmfa = 0, m_cmfb = 0, m_dma = 0, m_irq = 0, m_armed = 0, m_defer = 0;

    always #5 CLK = ~CLK;

    sh7604_ubc_match dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R),
        .BARA(BARA), .BAMRA(BAMRA), .BBRA(BBRA),
        .BARB(BARB), .BAMRB(BAMRB), .BBRB(BBRB),
        .BDRB(BDRB), .BDMRB(BDMRB), .BRCR(BRCR),
        .BUS_VALID(BUS_VALID), .BUS_A(BUS_A), .BUS_D(BUS_D),
        .BUS_WE(BUS_WE), .BUS_SZ(BUS_SZ), .BUS_IF(BUS_IF), .BUS_DMA(BUS_DMA),
        .INSN_END(INSN_END), .IRQ_ACK(IRQ_ACK),
        .CMFA_SET(CMFA_SET), .CMFB_SET(CMFB_SET), .CMF_DMA(CMF_DMA), .IRQ(IRQ)
    );

    function automatic bit m_addr(input logic [31:0] a, input logic [31:0] bar,
                                  input logic [31:0] mask);
        return (a & ~mask) == (bar & ~mask);
    endfunction

    // Field value 1 = first kind, 2 = second kind, 3 = both, 0 = none.
    function automatic bit m_qual(input logic [15:0] bbr, input bit dma, input bit ifc,
                                  input bit we, input logic [1:0] sz);
        int unsigned cp, id, rw, s;
        bit ok;
        cp = bbr[7:6]; id = bbr[5:4]; rw = bbr[3:2]; s = bbr[1:0];
        ok = 1;
        if (dma ? (cp < 2) : (cp % 2 == 0)) ok = 0;
        if (ifc ? (id % 2 == 0) : (id < 2)) ok = 0;
        if (we ? (rw < 2) : (rw % 2 == 0)) ok = 0;
        if (s != 0 && s != sz) ok = 0;
        return ok;
    endfunction

    function automatic bit m_data(input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] bdr, input logic [31:0] bdm,
                                  input logic [1:0] sz);
        int unsigned v, r, m, k;
        if (sz == 1) begin
            k = a[1:0];
            v = (d >> (8 * (3 - k))) & 32'hFF;
            r = bdr & 32'hFF;
            m = ~bdm & 32'hFF;
        end else if (sz == 2) begin
            v = a[1] ? (d & 32'hFFFF) : (d >> 16);
            r = bdr & 32'hFFFF;
            m = ~bdm & 32'hFFFF;
        end else begin
            v = d; r = bdr; m = ~bdm;
        end
        return ((v ^ r) & m) == 0;
    endfunction

    task automatic model_step();
        bit ma, mb, ba, bb, pa, pb, now, later, fire, busy;
        if (RST) begin
            m_cmfa = 0; m_cmfb = 0; m_dma = 0; m_irq = 0; m_armed = 0; m_defer = 0;
        end else if (CE_R) begin
            ma = BUS_VALID && m_addr(BUS_A, BARA, BAMRA)
                 && m_qual(BBRA, BUS_DMA, BUS_IF, BUS_WE, BUS_SZ);
            mb = BUS_VALID && m_addr(BUS_A, BARB, BAMRB)
                 && m_qual(BBRB, BUS_DMA, BUS_IF, BUS_WE, BUS_SZ)
                 && (!(BRCR[2] && !BUS_IF) || m_data(BUS_A, BUS_D, BDRB, BDMRB, BUS_SZ));
            ba = 0; bb = 0;
            if (!BRCR[3]) begin
                ba = ma; bb = mb; m_armed = 0;
            end else begin
                bb = mb && m_armed;
                if (ma) m_armed = 1;
                else if (bb) m_armed = 0;
            end
            pa = BUS_IF && BRCR[10];
            pb = BUS_IF && BRCR[1];
            now   = (ba && !pa) || (bb && !pb);
            later = (ba && pa) || (bb && pb);
            fire  = m_defer && INSN_END;
            busy  = m_irq && !IRQ_ACK;
            m_defer = (later && !busy) || (m_defer && !INSN_END);
            m_irq   = now || fire || busy;
            m_cmfa = ma; m_cmfb = mb; m_dma = BUS_DMA;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed expectation, applied to both the DUT and the model.
    task automatic pin(input string name, input logic dut_v, input bit mdl_v, input bit lit);
        chk(name, {31'b0, dut_v}, {31'b0, lit});
        chk({name, "_model"}, {31'b0, mdl_v}, {31'b0, lit});
    endtask

    // One clock: model advances with the DUT, all outputs compared 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        chk("cmfa", {31'b0, CMFA_SET}, {31'b0, m_cmfa});
        chk("cmfb", {31'b0, CMFB_SET}, {31'b0, m_cmfb});
        chk("cmfdma", {31'b0, CMF_DMA}, {31'b0, m_dma});
        chk("irq", {31'b0, IRQ}, {31'b0, m_irq});
        BUS_VALID = 0; INSN_END = 0; IRQ_ACK = 0;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input bit we,
                       input logic [1:0] sz, input bit ifc, input bit dma);
        BUS_VALID = 1; BUS_A = a; BUS_D = d; BUS_WE = we; BUS_SZ = sz;
        BUS_IF = ifc; BUS_DMA = dma;
    endtask

    initial begin
        RST = 1; CE_R = 1;
        BARA = '0; BAMRA = '0; BBRA = '0; BARB = '0; BAMRB = '0; BBRB = '0;
        BDRB = '0; BDMRB = '0; BRCR = '0;
        BUS_VALID = 0; BUS_A = '0; BUS_D = '0; BUS_WE = 0; BUS_SZ = 2'b11;
        BUS_IF = 0; BUS_DMA = 0; INSN_END = 0; IRQ_ACK = 0;
        tick(); tick();
        pin("rst_irq", IRQ, m_irq, 0);
        pin("rst_cmfa", CMFA_SET, m_cmfa, 0);
        RST = 0;

        // A: CPU data long write at 0x06001000
        BARA = 32'h0600_1000; BBRA = 16'h006B;
        bus(32'h0600_1000, 32'h1234_5678, 1, 2'b11, 0, 0); tick();
        pin("a_cmfa", CMFA_SET, m_cmfa, 1);
        pin("a_dma", CMF_DMA, m_dma, 0);
        pin("a_irq", IRQ, m_irq, 1);
        CE_R = 0; tick();
        pin("hold_cmfa", CMFA_SET, m_cmfa, 1);
        CE_R = 1; tick();
        pin("a_irq_held", IRQ, m_irq, 1);
        pin("a_cmfa_drop", CMFA_SET, m_cmfa, 0);
        IRQ_ACK = 1; tick();
        pin("a_ack", IRQ, m_irq, 0);
        bus(32'h0600_1004, 32'h0, 1, 2'b11, 0, 0); tick();
        pin("a_miss", CMFA_SET, m_cmfa, 0);
        pin("a_miss_irq", IRQ, m_irq, 0);

        // B: byte read with data compare
        BBRA = '0;
        BARB = 32'h0600_2000; BAMRB = 32'hF; BBRB = 16'h00E4;
        BDRB = 32'h0000_00AB; BDMRB = '0; BRCR = 16'h0004;
        bus(32'h0600_2003, 32'h0000_00AB, 0, 2'b01, 0, 0); tick();
        pin("b_cmfb", CMFB_SET, m_cmfb, 1);
        pin("b_irq", IRQ, m_irq, 1);
        IRQ_ACK = 1; tick();
        bus(32'h0600_2003, 32'h0000_00AC, 0, 2'b01, 0, 0); tick();
        pin("b_dmiss", CMFB_SET, m_cmfb, 0);
        pin("b_dmiss_irq", IRQ, m_irq, 0);

        // Sequential break
        BRCR = 16'h0008; BBRA = 16'h006B;
        bus(32'h0600_2003, 32'h0, 0, 2'b01, 0, 1); tick();
        pin("seq_b_only", CMFB_SET, m_cmfb, 1);
        pin("seq_b_dma", CMF_DMA, m_dma, 1);
        pin("seq_b_noirq", IRQ, m_irq, 0);
        bus(32'h0600_1000, 32'h0, 1, 2'b11, 0, 0); tick();
        pin("seq_a_noirq", IRQ, m_irq, 0);
        bus(32'h0600_2001, 32'h0, 0, 2'b10, 0, 0); tick();
        pin("seq_fire", IRQ, m_irq, 1);
        pin("seq_disarm", m_armed, m_armed, 0);
        IRQ_ACK = 1; tick();

        // PC break on A
        BRCR = 16'h0400; BBRA = 16'h0054;
        bus(32'h0600_1000, 32'h0, 0, 2'b10, 1, 0); tick();
        pin("pcb_cmfa", CMFA_SET, m_cmfa, 1);
        pin("pcb_noirq", IRQ, m_irq, 0);
        tick();
        pin("pcb_wait", IRQ, m_irq, 0);
        INSN_END = 1; tick();
        pin("pcb_fire", IRQ, m_irq, 1);
        IRQ_ACK = 1; tick();

        // ACK coinciding with a new break
        BRCR = '0; BBRA = 16'h006B;
        bus(32'h0600_1000, 32'h0, 1, 2'b11, 0, 0); tick();
        bus(32'h0600_1000, 32'h0, 1, 2'b11, 0, 0); IRQ_ACK = 1; tick();
        pin("ack_set_wins", IRQ, m_irq, 1);
        IRQ_ACK = 1; tick();
        pin("ack_alone", IRQ, m_irq, 0);

        // Reset discards DEFER and ARMED
        BRCR = 16'h0400; BBRA = 16'h0054;
        bus(32'h0600_1000, 32'h0, 0, 2'b10, 1, 0); tick();
        BRCR = 16'h0008;
        bus(32'h0600_1000, 32'h0, 0, 2'b10, 1, 0); tick();
        pin("pre_rst_defer", m_defer, m_defer, 1);
        RST = 1; tick();
        pin("rst2_irq", IRQ, m_irq, 0);
        pin("rst2_cmfa", CMFA_SET, m_cmfa, 0);
        RST = 0;
        INSN_END = 1; tick();
        pin("rst2_insn", IRQ, m_irq, 0);
        bus(32'h0600_2000, 32'h0, 0, 2'b11, 0, 0); tick();
        pin("rst2_bflag", CMFB_SET, m_cmfb, 1);
        pin("rst2_bnoirq", IRQ, m_irq, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] base;
            int unsigned pick;
            if (i % 250 == 0) begin
                BARA  = $urandom; BARB = $urandom;
                BAMRA = ($urandom % 2) ? 32'h0 : ($urandom & $urandom & 32'hFF);
                BAMRB = ($urandom % 2) ? 32'hF : ($urandom & $urandom);
                BBRA  = 16'($urandom & 32'hFF);
                BBRB  = 16'($urandom & 32'hFF);
                BDRB  = $urandom;
                BDMRB = ($urandom % 2) ? 32'h0 : ($urandom & $urandom);
                BRCR  = 16'($urandom & 32'h040E);
            end
            CE_R = ($urandom % 5) != 0;
            RST  = ($urandom % 400) == 0;
            pick = $urandom % 3;
            base = (pick == 0) ? BARA : (pick == 1) ? BARB : $urandom;
            BUS_VALID = $urandom % 2;
            BUS_A   = base ^ (($urandom % 2) ? 32'h0 : ($urandom & 32'h7));
            pick    = $urandom % 4;
            BUS_D   = (pick == 0) ? {4{BDRB[7:0]}} : (pick == 1) ? {2{BDRB[15:0]}} :
                      (pick == 2) ? BDRB : $urandom;
            BUS_WE  = $urandom % 2;
            BUS_IF  = $urandom % 2;
            BUS_DMA = $urandom % 2;
            BUS_SZ  = 2'(1 + $urandom % 3);
            INSN_END = ($urandom % 4) == 0;
            IRQ_ACK  = ($urandom % 6) == 0;
            tick();
        end
        RST = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
